tb_port_capture: RTL and testbench



---
 rtl/tb_port_capture.sv | 88 ++++++++
 tb/tb_tb_port_capture.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_port_capture.sv
// tb_port_capture: snoops the data-memory write bus, frames test-port words and queues them for the checker
module tb_port_capture #(
  parameter logic [29:0] PORT_ADDR = 30'hFF,
  parameter logic [31:0] BEGIN_SYM = 32'h00000168,
  parameter logic [31:0] END_SYM = 32'hFFFFFD5D,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wen,
  input  logic        bus_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [6:0]  out_index,
  output logic        out_last,
  input  logic        out_ready,
  output logic        armed,
  output logic        done,
  output logic        overflow,
  output logic [15:0] cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state;
  logic [39:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_n;
  logic [CW-1:0] count, count_n;
  logic [6:0] seq;
  logic [31:0] w;
  logic [39:0] entry, head_n;
  logic hit, push, pop, acc;
  assign w = {bus_wdata[7:0], bus_wdata[15:8], bus_wdata[23:16], bus_wdata[31:24]};
  assign hit = bus_wen && bus_ready && bus_addr == PORT_ADDR;
  assign push = hit && state == ARMED;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  assign acc = push && (count != FULL || pop);
  assign entry = {w, seq, w == END_SYM};
  assign rd_n = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_n = count + CW'(acc) - CW'(pop);
  assign head_n = count_n == '0 ? '0 : (acc && wr_ptr == rd_n) ? entry : mem[rd_n];
  // frame state machine with sequence counter, armed-cycle counter and sticky flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      seq <= '0;
      cycles <= '0;
      armed <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE) begin
      if (hit && w == BEGIN_SYM) begin
        state <= ARMED;
        armed <= 1'b1;
        seq <= '0;
        cycles <= 16'd1;
      end
    end else if (state == ARMED) begin
      cycles <= cycles + 16'(cycles != 16'hFFFF);
      if (push) seq <= seq + 7'd1;
      if (push && !acc) overflow <= 1'b1;
      if (push && w == END_SYM) begin
        state <= DONE;
        armed <= 1'b0;
        done <= 1'b1;
      end
    end
  // FIFO pointers, occupancy and the registered head word presented to the checker
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      {out_data, out_index, out_last} <= '0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_n;
      count <= count_n;
      {out_data, out_index, out_last} <= head_n;
    end
  // FIFO storage; occupancy alone decides validity so the array needs no reset
  always_ff @(posedge clk)
    if (acc) mem[wr_ptr] <= entry;
endmodule

// File: tb/tb_tb_port_capture.sv
// tb_tb_port_capture: vector table, corner sequences and random traffic against a queue model
module tb_tb_port_capture;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic bus_wen, bus_ready, out_ready;
  logic out_valid, out_last, armed, done, overflow;
  logic [31:0] out_data;
  logic [6:0] out_index;
  logic [15:0] cycles;
  int checks = 0;
  int errors = 0;
  int m_state;
  logic [39:0] m_q[$];
  logic [6:0] m_seq;
  int m_cycles;
  bit m_ovf;
  localparam logic [31:0] BSYM = 32'h00000168;
  localparam logic [31:0] ESYM = 32'hFFFFFD5D;

  tb_port_capture dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen),
    .bus_ready(bus_ready), .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .out_ready(out_ready), .armed(armed), .done(done),
    .overflow(overflow), .cycles(cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic wen, rdy;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic ordy, valid;
    logic [31:0] data;
    logic [6:0] idx;
    logic last, arm, dn;
    logic [15:0] cyc;
  } vec_t;
  vec_t tv[10];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] le(logic [31:0] v);
    logic [31:0] r;
    r = {<<8{v}};
    return r;
  endfunction

  task automatic model_clear();
    m_state = 0;
    m_q.delete();
    m_seq = 7'd0;
    m_cycles = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    bit hit;
    w = {<<8{bus_wdata}};
    hit = bus_wen && bus_ready && bus_addr == 30'hFF;
    if (m_q.size() != 0 && out_ready) m_q.delete(0);
    if (m_state == 1 && m_cycles < 65535) m_cycles++;
    if (hit && m_state == 0 && w == BSYM) begin
      m_state = 1;
      m_seq = 7'd0;
      m_cycles = 1;
    end else if (hit && m_state == 1) begin
      if (m_q.size() < 8) m_q.push_back({w, m_seq, w == ESYM});
      else m_ovf = 1'b1;
      m_seq = m_seq + 7'd1;
      if (w == ESYM) m_state = 2;
    end
  endtask

  task automatic cmp_model(string tag);
    logic [39:0] h;
    h = m_q.size() != 0 ? m_q[0] : 40'd0;
    check({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    check({tag, ".data"}, out_data, h[39:8]);
    check({tag, ".index"}, 32'(out_index), 32'(h[7:1]));
    check({tag, ".last"}, 32'(out_last), 32'(h[0]));
    check({tag, ".armed"}, 32'(armed), 32'(m_state == 1));
    check({tag, ".done"}, 32'(done), 32'(m_state == 2));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".cycles"}, 32'(cycles), 32'(m_cycles));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepc(string tag);
    step();
    cmp_model(tag);
  endtask

  task automatic wr(logic [31:0] v);
    bus_wen = 1'b1;
    bus_ready = 1'b1;
    bus_addr = 30'hFF;
    bus_wdata = le(v);
    stepc("wr");
    bus_wen = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus_wen = 1'b0;
    bus_ready = 1'b1;
    bus_addr = 30'hFF;
    bus_wdata = 32'd0;
    out_ready = 1'b0;
    model_clear();
    #1;
    cmp_model("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] ld;
    logic [6:0] li;
    do_reset();

    tv[0] = '{1'b1, 1'b1, 30'hFF, 32'h01000000, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[1] = '{1'b1, 1'b0, 30'hFF, 32'h68010000, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[2] = '{1'b1, 1'b1, 30'hFF, 32'h68010000, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0, 1'b1, 1'b0, 16'd1};
    tv[3] = '{1'b1, 1'b1, 30'hFE, 32'h00000000, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0, 1'b1, 1'b0, 16'd2};
    tv[4] = '{1'b0, 1'b1, 30'hFF, 32'h02000000, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0, 1'b1, 1'b0, 16'd3};
    tv[5] = '{1'b1, 1'b1, 30'hFF, 32'h00000000, 1'b1, 1'b1, 32'h0, 7'd0, 1'b0, 1'b1, 1'b0, 16'd4};
    tv[6] = '{1'b1, 1'b1, 30'hFF, 32'h01000000, 1'b1, 1'b1, 32'h1, 7'd1, 1'b0, 1'b1, 1'b0, 16'd5};
    tv[7] = '{1'b1, 1'b1, 30'hFF, 32'h5DFDFFFF, 1'b1, 1'b1, ESYM, 7'd2, 1'b1, 1'b0, 1'b1, 16'd6};
    tv[8] = '{1'b1, 1'b1, 30'hFF, 32'h03000000, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0, 1'b1, 16'd6};
    tv[9] = '{1'b0, 1'b1, 30'hFF, 32'h00000000, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0, 1'b1, 16'd6};
    for (int i = 0; i < 10; i++) begin
      bus_wen = tv[i].wen;
      bus_ready = tv[i].rdy;
      bus_addr = tv[i].addr;
      bus_wdata = tv[i].wdata;
      out_ready = tv[i].ordy;
      step();
      check($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tv[i].valid));
      check($sformatf("vec%0d.data", i), out_data, tv[i].data);
      check($sformatf("vec%0d.index", i), 32'(out_index), 32'(tv[i].idx));
      check($sformatf("vec%0d.last", i), 32'(out_last), 32'(tv[i].last));
      check($sformatf("vec%0d.armed", i), 32'(armed), 32'(tv[i].arm));
      check($sformatf("vec%0d.done", i), 32'(done), 32'(tv[i].dn));
      check($sformatf("vec%0d.cycles", i), 32'(cycles), 32'(tv[i].cyc));
      check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'd0);
    end

    do_reset();
    wr(BSYM);
    out_ready = 1'b0;
    bus_wen = 1'b1;
    bus_ready = 1'b0;
    bus_addr = 30'hFF;
    bus_wdata = le(32'd7);
    repeat (3) stepc("stall");
    check("stall.novalid", 32'(out_valid), 32'd0);
    bus_ready = 1'b1;
    stepc("stall_go");
    bus_wen = 1'b0;
    check("stall.valid", 32'(out_valid), 32'd1);
    check("stall.index", 32'(out_index), 32'd0);
    check("stall.data", out_data, 32'd7);
    wr(32'd8);
    out_ready = 1'b1;
    stepc("stall_pop");
    check("stall.next_index", 32'(out_index), 32'd1);
    check("stall.next_data", out_data, 32'd8);

    do_reset();
    wr(BSYM);
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(32'(100 + i));
    check("ovf.flag", 32'(overflow), 32'd1);
    check("ovf.valid", 32'(out_valid), 32'd1);
    check("ovf.head_index", 32'(out_index), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovf.drain%0d.index", k), 32'(out_index), 32'(k));
      check($sformatf("ovf.drain%0d.data", k), out_data, 32'(100 + k));
      stepc("ovf_drain");
    end
    check("ovf.empty", 32'(out_valid), 32'd0);

    do_reset();
    wr(BSYM);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(32'(i + 1));
    check("full.valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wr(32'd200);
    check("full.no_overflow", 32'(overflow), 32'd0);
    n = 0;
    ld = 32'd0;
    li = 7'd0;
    while (out_valid && n < 20) begin
      ld = out_data;
      li = out_index;
      n++;
      stepc("full_drain");
    end
    check("full.count", 32'(n), 32'd8);
    check("full.tail_data", ld, 32'd200);
    check("full.tail_index", 32'(li), 32'd8);

    do_reset();
    wr(BSYM);
    repeat (20) stepc("idle");
    wr(ESYM);
    check("cyc.count", 32'(cycles), 32'd22);
    check("cyc.done", 32'(done), 32'd1);
    check("cyc.armed", 32'(armed), 32'd0);

    do_reset();
    wr(BSYM);
    out_ready = 1'b0;
    wr(32'd5);
    wr(32'd6);
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    cmp_model("async_rst");
    check("async_rst.valid", 32'(out_valid), 32'd0);
    check("async_rst.cycles", 32'(cycles), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr(32'd9);
    check("rearm.valid", 32'(out_valid), 32'd0);
    check("rearm.armed", 32'(armed), 32'd0);

    for (int b = 0; b < 6; b++) begin
      do_reset();
      wr(BSYM);
      for (int c = 0; c < 400; c++) begin
        int r;
        r = $urandom_range(0, 99);
        bus_wen = $urandom_range(0, 9) < 6;
        bus_ready = $urandom_range(0, 9) < 7;
        bus_addr = $urandom_range(0, 9) < 8 ? 30'hFF : 30'($urandom);
        bus_wdata = r < 5 ? le(BSYM) : r < 7 ? le(ESYM) : r < 50 ? 32'($urandom_range(0, 15)) : $urandom;
        out_ready = $urandom_range(0, 4) < b;
        stepc("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
